// File: rtl/snake_pkg.sv
// Shared board-state codes and default palette for the snake VGA tile renderer.
package snake_pkg;

   localparam int EMPTY      = 0;
   localparam int FOOD       = 1;
   localparam int BODY_FIRST = 2;
   localparam int BODY_LAST  = 5;
   localparam int HEAD_UP    = 6;
   localparam int HEAD_DOWN  = 7;
   localparam int HEAD_LEFT  = 8;
   localparam int HEAD_RIGHT = 9;

   localparam int STATE_W_DFLT = 4;
   localparam int EYE_IDX      = 2**STATE_W_DFLT - 1;

   localparam logic [11:0] DEFAULT_PAL [16] = '{
      12'hfff, 12'hf00, 12'hfc1, 12'hfc1, 12'hfc1, 12'hfc1, 12'habc, 12'habc,
      12'habc, 12'habc, 12'hfff, 12'hfff, 12'hfff, 12'hfff, 12'hfff, 12'h000
   };

   // The last entry of any palette depth is the eye colour; extra entries beyond 16 read as empty.
   function automatic logic [11:0] default_rgb(input int idx, input int depth);
      if (idx == depth - 1)
         return 12'h000;
      else if (idx < 16)
         return DEFAULT_PAL[idx];
      else
         return 12'hfff;
   endfunction

endpackage

// File: rtl/tile_palette.sv
// Palette register file: one synchronous write port, one combinational read port
// that the caller registers; async active-low reset reloads the default colours.
module tile_palette
   import snake_pkg::*;
#(
   parameter int STATE_W = 4,
   parameter int COLOR_W = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [STATE_W-1:0] waddr,
   input  logic [COLOR_W-1:0] wdata,
   input  logic [STATE_W-1:0] raddr,
   output logic [COLOR_W-1:0] rdata
);

   localparam int DEPTH = 2**STATE_W;

   logic [COLOR_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= COLOR_W'(default_rgb(i, DEPTH));
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read happens before the same-edge write lands, so collisions return the old colour.
   assign rdata = mem[raddr];

endmodule

// File: rtl/snake_tile_renderer.sv
// Two-stage per-pixel tile renderer: S1 decodes the board code into a palette
// index, S2 looks the index up and registers the blanked RGB.
module snake_tile_renderer
   import snake_pkg::*;
#(
   parameter int TILE_LOG2  = 5,
   parameter int MARGIN     = 4,
   parameter int COLOR_W    = 12,
   parameter int STATE_W    = 4,
   parameter int XY_W       = 10,
   parameter int BLINK_LOG2 = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [STATE_W-1:0] blockState,
   input  logic [XY_W-1:0]    x_ptr,
   input  logic [XY_W-1:0]    y_ptr,
   input  logic               frame_start,
   input  logic               pal_we,
   input  logic [STATE_W-1:0] pal_addr,
   input  logic [COLOR_W-1:0] pal_data,
   output logic [COLOR_W-1:0] RGB,
   output logic               out_valid
);

   localparam logic [TILE_LOG2-1:0] M_LO    = TILE_LOG2'(MARGIN);
   localparam logic [TILE_LOG2-1:0] M_HI    = TILE_LOG2'(2**TILE_LOG2 - MARGIN);
   localparam logic [STATE_W-1:0]   EYE_SEL = STATE_W'(2**STATE_W - 1);

   logic [BLINK_LOG2-1:0] fcnt;
   logic                  blink;
   logic [TILE_LOG2-1:0]  lx, ly;
   logic [2:0]            cx, cy;
   logic                  food_in, gap, eye;
   logic [STATE_W-1:0]    sel;
   logic                  vld_p1;
   logic [STATE_W-1:0]    sel_p1;
   logic [COLOR_W-1:0]    pal_rdata;
   logic                  unused_hi;

   assign unused_hi = ^{x_ptr[XY_W-1:TILE_LOG2], y_ptr[XY_W-1:TILE_LOG2]};

   assign lx    = x_ptr[TILE_LOG2-1:0];
   assign ly    = y_ptr[TILE_LOG2-1:0];
   assign cx    = lx[TILE_LOG2-1 -: 3];
   assign cy    = ly[TILE_LOG2-1 -: 3];
   assign blink = fcnt[BLINK_LOG2-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         fcnt <= '0;
      else if (frame_start)
         fcnt <= fcnt + 1'b1;
   end

   assign food_in = (lx >= M_LO) && (lx < M_HI) && (ly >= M_LO) && (ly < M_HI);
   assign gap     = (lx == '0) || (ly == '0);

   always_comb begin
      eye = 1'b0;
      case (blockState)
         STATE_W'(HEAD_UP):    eye = (cy == 3'd1) && (cx == 3'd2 || cx == 3'd5);
         STATE_W'(HEAD_DOWN):  eye = (cy == 3'd6) && (cx == 3'd2 || cx == 3'd5);
         STATE_W'(HEAD_LEFT):  eye = (cx == 3'd1) && (cy == 3'd2 || cy == 3'd5);
         STATE_W'(HEAD_RIGHT): eye = (cx == 3'd6) && (cy == 3'd2 || cy == 3'd5);
         default:              eye = 1'b0;
      endcase
   end

   // Codes outside the known ranges fall through to the empty colour.
   always_comb begin
      sel = STATE_W'(EMPTY);
      if (blockState == STATE_W'(FOOD)) begin
         if (food_in && !blink)
            sel = STATE_W'(FOOD);
      end else if (blockState >= STATE_W'(BODY_FIRST) && blockState <= STATE_W'(BODY_LAST)) begin
         if (!gap)
            sel = blockState;
      end else if (blockState >= STATE_W'(HEAD_UP) && blockState <= STATE_W'(HEAD_RIGHT)) begin
         sel = eye ? EYE_SEL : blockState;
      end
   end

   // S1: valid and resolved palette index
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         vld_p1 <= 1'b0;
      else
         vld_p1 <= in_valid;
   end

   always_ff @(posedge clk) begin
      sel_p1 <= sel;
   end

   tile_palette #(
      .STATE_W (STATE_W),
      .COLOR_W (COLOR_W)
   ) u_palette (
      .clk   (clk),
      .rst   (rst),
      .we    (pal_we),
      .waddr (pal_addr),
      .wdata (pal_data),
      .raddr (sel_p1),
      .rdata (pal_rdata)
   );

   // S2: palette lookup with blanking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RGB       <= '0;
         out_valid <= 1'b0;
      end else begin
         RGB       <= vld_p1 ? pal_rdata : '0;
         out_valid <= vld_p1;
      end
   end

endmodule

// File: tb/tb_snake_tile_renderer.sv
// Bench for snake_tile_renderer: directed test-plan steps plus random traffic
// checked every cycle against a rule-level reference model.
module tb_snake_tile_renderer;

   localparam int T          = 32;
   localparam int M          = 4;
   localparam int BLINK_LOG2 = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [3:0]  blockState;
   logic [9:0]  x_ptr, y_ptr;
   logic        frame_start;
   logic        pal_we;
   logic [3:0]  pal_addr;
   logic [11:0] pal_data;
   logic [11:0] RGB;
   logic        out_valid;

   int n_tests = 0;
   int n_fail  = 0;

   logic [11:0] pal_m [16];
   int          fcnt_m;
   bit          pend_v;
   int          pend_idx;
   logic [11:0] exp_rgb;
   bit          exp_v;

   always #5 clk = ~clk;

   snake_tile_renderer dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .blockState  (blockState),
      .x_ptr       (x_ptr),
      .y_ptr       (y_ptr),
      .frame_start (frame_start),
      .pal_we      (pal_we),
      .pal_addr    (pal_addr),
      .pal_data    (pal_data),
      .RGB         (RGB),
      .out_valid   (out_valid)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   // Palette entry selected for a pixel, straight from the colour rules.
   function automatic int sel_idx(int code, int lx, int ly, bit blink);
      int cx = lx / (T / 8);
      int cy = ly / (T / 8);
      if (code == 1)
         return (lx >= M && lx < T - M && ly >= M && ly < T - M && !blink) ? 1 : 0;
      if (code >= 2 && code <= 5)
         return (lx == 0 || ly == 0) ? 0 : code;
      if (code == 6) return (cy == 1 && (cx == 2 || cx == 5)) ? 15 : 6;
      if (code == 7) return (cy == 6 && (cx == 2 || cx == 5)) ? 15 : 7;
      if (code == 8) return (cx == 1 && (cy == 2 || cy == 5)) ? 15 : 8;
      if (code == 9) return (cx == 6 && (cy == 2 || cy == 5)) ? 15 : 9;
      return 0;
   endfunction

   task automatic model_reset();
      pal_m = '{12'hfff, 12'hf00, 12'hfc1, 12'hfc1, 12'hfc1, 12'hfc1, 12'habc, 12'habc,
                12'habc, 12'habc, 12'hfff, 12'hfff, 12'hfff, 12'hfff, 12'hfff, 12'h000};
      fcnt_m  = 0;
      pend_v  = 0;
      pend_idx = 0;
      exp_rgb = 12'h000;
      exp_v   = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      exp_rgb = pend_v ? pal_m[pend_idx] : 12'h000;
      exp_v   = pend_v;
      if (pal_we) pal_m[pal_addr] = pal_data;
      pend_v   = in_valid;
      pend_idx = sel_idx(int'(blockState), int'(x_ptr) % T, int'(y_ptr) % T,
                         ((fcnt_m >> (BLINK_LOG2 - 1)) & 1) == 1);
      if (frame_start) fcnt_m = (fcnt_m + 1) % (1 << BLINK_LOG2);
      #1;
      chk("rgb_model", {20'd0, RGB}, {20'd0, exp_rgb});
      chk("valid_model", {31'd0, out_valid}, {31'd0, exp_v});
   endtask

   task automatic pix(input int c, input int x, input int y, input logic [11:0] want, input string tag);
      blockState = 4'(c);
      x_ptr      = 10'(x);
      y_ptr      = 10'(y);
      in_valid   = 1'b1;
      tick();
      in_valid   = 1'b0;
      tick();
      chk(tag, {20'd0, RGB}, {20'd0, want});
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; blockState = '0; x_ptr = '0; y_ptr = '0;
      frame_start = 1'b0; pal_we = 1'b0; pal_addr = '0; pal_data = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rgb", {20'd0, RGB}, 32'h0);
      chk("reset_valid", {31'd0, out_valid}, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // First pixel after reset: nothing after one edge, body colour after two.
      blockState = 4'd2; x_ptr = 10'd5; y_ptr = 10'd5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("first_lat1_rgb", {20'd0, RGB}, 32'h0);
      tick();
      chk("first_lat2_rgb", {20'd0, RGB}, 32'hfc1);
      chk("first_lat2_valid", {31'd0, out_valid}, 32'h1);

      pix(1, 64 + 3,  64 + 10, 12'hfff, "food_lx3");
      pix(1, 64 + 4,  64 + 4,  12'hf00, "food_lx4");
      pix(1, 64 + 27, 64 + 10, 12'hf00, "food_lx27");
      pix(1, 64 + 28, 64 + 10, 12'hfff, "food_lx28");

      frame_start = 1'b1;
      repeat (16) tick();
      frame_start = 1'b0;
      pix(1, 64 + 4, 64 + 4, 12'hfff, "food_blink_on");
      frame_start = 1'b1;
      repeat (16) tick();
      frame_start = 1'b0;
      pix(1, 64 + 4, 64 + 4, 12'hf00, "food_blink_wrap");

      pix(6, 32 + 8,  32 + 4, 12'h000, "head_up_eye");
      pix(6, 32 + 12, 32 + 4, 12'habc, "head_up_noeye");
      pix(9, 32 + 24, 32 + 8, 12'h000, "head_right_eye");
      pix(9, 32 + 24, 32 + 4, 12'habc, "head_right_noeye");

      blockState = 4'd6; x_ptr = 10'd40; y_ptr = 10'd40; in_valid = 1'b0;
      tick();
      tick();
      chk("blank_rgb", {20'd0, RGB}, 32'h0);
      chk("blank_valid", {31'd0, out_valid}, 32'h0);
      pix(3, 32, 40, 12'hfff, "body_gap");

      // Write to entry 2 on the edge where a code-2 pixel is being looked up.
      blockState = 4'd2; x_ptr = 10'd37; y_ptr = 10'd37; in_valid = 1'b1;
      tick();
      pal_we = 1'b1; pal_addr = 4'd2; pal_data = 12'h0f0;
      tick();
      pal_we = 1'b0;
      in_valid = 1'b0;
      chk("collision_old", {20'd0, RGB}, 32'hfc1);
      tick();
      chk("collision_new", {20'd0, RGB}, 32'h0f0);

      // Async reset in the middle of a valid stream.
      blockState = 4'd2; in_valid = 1'b1;
      repeat (3) tick();
      #1;
      rst = 1'b0;
      #1;
      chk("async_rst_rgb", {20'd0, RGB}, 32'h0);
      chk("async_rst_valid", {31'd0, out_valid}, 32'h0);
      model_reset();
      in_valid = 1'b0;
      #1;
      rst = 1'b1;
      tick();
      pix(2, 37, 37, 12'hfc1, "rst_pal_revert");

      for (int i = 0; i < 600; i++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         blockState  = 4'($urandom_range(0, 15));
         x_ptr       = 10'($urandom_range(0, 639));
         y_ptr       = 10'($urandom_range(0, 479));
         frame_start = ($urandom_range(0, 7) == 0);
         pal_we      = ($urandom_range(0, 15) == 0);
         pal_addr    = 4'($urandom_range(0, 15));
         pal_data    = 12'($urandom);
         tick();
      end
      in_valid = 1'b0; frame_start = 1'b0; pal_we = 1'b0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
